tube_scanner: RTL and testbench



---
 rtl/tube_pkg.sv | 24 ++
 rtl/hex_seg_decode.sv | 11 +
 rtl/tube_scanner.sv | 114 +++++++++++
 tb/tb_tube_scanner.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/tube_pkg.sv
// tube_pkg: segment table, segment bit positions and digit-select helper
// shared by the tube_scanner display driver.
package tube_pkg;

    localparam int SEG_A  = 0;
    localparam int SEG_B  = 1;
    localparam int SEG_C  = 2;
    localparam int SEG_D  = 3;
    localparam int SEG_E  = 4;
    localparam int SEG_F  = 5;
    localparam int SEG_G  = 6;
    localparam int SEG_DP = 7;

    // Entry n holds the a..g pattern for hex digit n (entry 15 listed first).
    localparam logic [15:0][6:0] SEG_TABLE = {
        7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
        7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
    };

    function automatic logic [7:0] onehot_dig(input logic [2:0] idx);
        return 8'h01 << idx;
    endfunction

endpackage

// File: rtl/hex_seg_decode.sv
// hex_seg_decode: combinational hex nibble to a..g segment pattern.
module hex_seg_decode
    import tube_pkg::*;
(
    input  logic [3:0] nib_i,
    output logic [6:0] seg_o
);

    assign seg_o = SEG_TABLE[nib_i];

endmodule

// File: rtl/tube_scanner.sv
// tube_scanner: self-timed multiplexed 7-segment driver with frame-aligned
// double buffering, blanking, dead time and PWM. TUBE_SCANNER_LZS_EN adds leading-zero suppression.
module tube_scanner
    import tube_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int TICK_DIV   = 1000,
    parameter int DEAD_TICKS = 1
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dots,
    input  logic [NUM_DIGITS-1:0]   blank,
    input  logic                    load,
    input  logic [3:0]              brightness,
    output logic [NUM_DIGITS-1:0]   tubeDig,
    output logic [7:0]              tubeSeg,
    output logic                    frame_done
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int DW = $clog2(NUM_DIGITS);

    logic [TW-1:0]              tick_q;
    logic [3:0]                 phase_q;
    logic [DW-1:0]              dig_q;
    logic [NUM_DIGITS-1:0][3:0] val_stg_q, val_disp_q;
    logic [NUM_DIGITS-1:0]      dots_stg_q, dots_disp_q, blank_stg_q, blank_disp_q;
    logic                       pending_q;
    logic [NUM_DIGITS-1:0]      dig_out_q;
    logic [7:0]                 seg_out_q;
    logic                       frame_q;

    logic                       tick_en, slot_end, wrap, lit_d;
    logic [NUM_DIGITS-1:0]      hide, dig_oh;
    logic [7:0]                 oh8;
    logic [6:0]                 seg_d;

    assign tick_en  = tick_q == TW'(TICK_DIV - 1);
    assign slot_end = tick_en && phase_q == 4'hF;
    assign wrap     = slot_end && dig_q == DW'(NUM_DIGITS - 1);
    assign oh8      = onehot_dig(3'(dig_q));
    assign dig_oh   = oh8[NUM_DIGITS-1:0];

`ifdef TUBE_SCANNER_LZS_EN
    logic zero_run;
    // Walk down from the top digit; suppression stops at the first non-zero nibble.
    always_comb begin
        hide     = blank_disp_q;
        zero_run = 1'b1;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            zero_run = zero_run && val_disp_q[i] == 4'h0;
            hide[i]  = hide[i] | (zero_run & ~dots_disp_q[i]);
        end
    end
`else
    assign hide = blank_disp_q;
`endif

    assign lit_d = phase_q >= 4'(DEAD_TICKS) && phase_q <= brightness &&
                   brightness != 4'h0 && !hide[dig_q];

    hex_seg_decode u_dec (
        .nib_i (val_disp_q[dig_q]),
        .seg_o (seg_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_q       <= '0;
            phase_q      <= '0;
            dig_q        <= '0;
            val_stg_q    <= '0;
            val_disp_q   <= '0;
            dots_stg_q   <= '0;
            dots_disp_q  <= '0;
            blank_stg_q  <= '0;
            blank_disp_q <= '0;
            pending_q    <= 1'b0;
            dig_out_q    <= '0;
            seg_out_q    <= '0;
            frame_q      <= 1'b0;
        end else begin
            tick_q <= tick_en ? '0 : tick_q + 1'b1;
            if (tick_en) phase_q <= phase_q + 1'b1;
            if (slot_end) dig_q <= wrap ? '0 : dig_q + 1'b1;
            if (load) begin
                val_stg_q   <= value;
                dots_stg_q  <= dots;
                blank_stg_q <= blank;
            end
            // A load landing on the wrap edge bypasses staging.
            if (wrap && load) begin
                val_disp_q   <= value;
                dots_disp_q  <= dots;
                blank_disp_q <= blank;
            end else if (wrap && pending_q) begin
                val_disp_q   <= val_stg_q;
                dots_disp_q  <= dots_stg_q;
                blank_disp_q <= blank_stg_q;
            end
            pending_q <= !wrap && (load || pending_q);
            frame_q   <= wrap;
            dig_out_q <= lit_d ? dig_oh : '0;
            seg_out_q <= lit_d ? {dots_disp_q[dig_q], seg_d} : '0;
        end
    end

    assign tubeDig    = dig_out_q;
    assign tubeSeg    = seg_out_q;
    assign frame_done = frame_q;

endmodule

// File: tb/tb_tube_scanner.sv
// tb_tube_scanner: directed table-driven bench for tube_scanner
// (NUM_DIGITS=4, TICK_DIV=2, DEAD_TICKS=1: slot = 32 clk, frame = 128 clk).
module tb_tube_scanner;

    typedef struct {
        int         cyc;
        logic [3:0] br;
        logic       ld;
        logic [15:0] val;
        logic [3:0] dots;
        logic [3:0] blank;
        logic [3:0] edig;
        logic [7:0] eseg;
        logic       efd;
    } row_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] value = '0;
    logic [3:0]  dots = '0;
    logic [3:0]  blank = '0;
    logic        load = 1'b0;
    logic [3:0]  brightness = '0;
    logic [3:0]  tubeDig;
    logic [7:0]  tubeSeg;
    logic        frame_done;

    int n_cmp = 0;
    int n_err = 0;
    int cyc;
    row_t t1[$];
    row_t t2[$];

    tube_scanner #(.NUM_DIGITS(4), .TICK_DIV(2), .DEAD_TICKS(1)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .value      (value),
        .dots       (dots),
        .blank      (blank),
        .load       (load),
        .brightness (brightness),
        .tubeDig    (tubeDig),
        .tubeSeg    (tubeSeg),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Edge count since the last reset release; edge k of the DUT is cyc == k.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    function automatic row_t r(input int c, input logic [3:0] b, input logic l,
                               input logic [15:0] v, input logic [3:0] d, input logic [3:0] bl,
                               input logic [3:0] ed, input logic [7:0] es, input logic ef);
        row_t x;
        x.cyc = c; x.br = b; x.ld = l; x.val = v; x.dots = d; x.blank = bl;
        x.edig = ed; x.eseg = es; x.efd = ef;
        return x;
    endfunction

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", nm, cyc, got, exp);
        end
    endtask

    task automatic wait_to(input int n);
        while (cyc < n) begin
            @(posedge clk);
            #1;
            load = 1'b0;
        end
    endtask

    task automatic do_row(input row_t x, input string tag);
        wait_to(x.cyc);
        chk($sformatf("%s@%0d dig", tag, x.cyc), 32'(tubeDig), 32'(x.edig));
        chk($sformatf("%s@%0d seg", tag, x.cyc), 32'(tubeSeg), 32'(x.eseg));
        chk($sformatf("%s@%0d fd", tag, x.cyc), 32'(frame_done), 32'(x.efd));
        brightness = x.br;
        value      = x.val;
        dots       = x.dots;
        blank      = x.blank;
        load       = x.ld;
    endtask

    initial begin
        // Scan, load/buffer, PWM and blanking sequence from reset.
        t1.push_back(r(  1,  0, 0, 16'h0000, 4'b0000, 4'b0000, 4'h0, 8'h00, 0));
        t1.push_back(r( 40,  0, 0, 16'h0000, 4'b0000, 4'b0000, 4'h0, 8'h00, 0));
        t1.push_back(r(100,  0, 0, 16'h0000, 4'b0000, 4'b0000, 4'h0, 8'h00, 0));
        t1.push_back(r(127,  0, 0, 16'h0000, 4'b0000, 4'b0000, 4'h0, 8'h00, 0));
        t1.push_back(r(128, 15, 0, 16'h0000, 4'b0000, 4'b0000, 4'h0, 8'h00, 1));
        t1.push_back(r(129, 15, 0, 16'h0000, 4'b0000, 4'b0000, 4'h0, 8'h00, 0));
        t1.push_back(r(130, 15, 0, 16'h0000, 4'b0000, 4'b0000, 4'h0, 8'h00, 0));
        t1.push_back(r(131, 15, 0, 16'h0000, 4'b0000, 4'b0000, 4'h1, 8'h3F, 0));
        t1.push_back(r(160, 15, 0, 16'h0000, 4'b0000, 4'b0000, 4'h1, 8'h3F, 0));
        t1.push_back(r(161, 15, 0, 16'h0000, 4'b0000, 4'b0000, 4'h0, 8'h00, 0));
        t1.push_back(r(163, 15, 0, 16'h0000, 4'b0000, 4'b0000, 4'h2, 8'h3F, 0));
        t1.push_back(r(170, 15, 1, 16'h1A2F, 4'b0100, 4'b0000, 4'h2, 8'h3F, 0));
        t1.push_back(r(180, 15, 0, 16'h0000, 4'b0000, 4'b0000, 4'h2, 8'h3F, 0));
        t1.push_back(r(240, 15, 0, 16'h0000, 4'b0000, 4'b0000, 4'h8, 8'h3F, 0));
        t1.push_back(r(255, 15, 0, 16'h0000, 4'b0000, 4'b0000, 4'h8, 8'h3F, 0));
        t1.push_back(r(256, 15, 0, 16'h0000, 4'b0000, 4'b0000, 4'h8, 8'h3F, 1));
        t1.push_back(r(259, 15, 0, 16'h0000, 4'b0000, 4'b0000, 4'h1, 8'h71, 0));
        t1.push_back(r(291, 15, 0, 16'h0000, 4'b0000, 4'b0000, 4'h2, 8'h5B, 0));
        t1.push_back(r(323, 15, 0, 16'h0000, 4'b0000, 4'b0000, 4'h4, 8'hF7, 0));
        t1.push_back(r(355, 15, 0, 16'h0000, 4'b0000, 4'b0000, 4'h8, 8'h06, 0));
        t1.push_back(r(384,  4, 0, 16'h0000, 4'b0000, 4'b0000, 4'h8, 8'h06, 1));
        t1.push_back(r(385,  4, 0, 16'h0000, 4'b0000, 4'b0000, 4'h0, 8'h00, 0));
        t1.push_back(r(387,  4, 0, 16'h0000, 4'b0000, 4'b0000, 4'h1, 8'h71, 0));
        t1.push_back(r(394,  4, 0, 16'h0000, 4'b0000, 4'b0000, 4'h1, 8'h71, 0));
        t1.push_back(r(395,  4, 0, 16'h0000, 4'b0000, 4'b0000, 4'h0, 8'h00, 0));
        t1.push_back(r(410,  4, 0, 16'h0000, 4'b0000, 4'b0000, 4'h0, 8'h00, 0));
        t1.push_back(r(420,  0, 0, 16'h0000, 4'b0000, 4'b0000, 4'h2, 8'h5B, 0));
        t1.push_back(r(421,  0, 0, 16'h0000, 4'b0000, 4'b0000, 4'h0, 8'h00, 0));
        t1.push_back(r(423,  0, 0, 16'h0000, 4'b0000, 4'b0000, 4'h0, 8'h00, 0));
        t1.push_back(r(430, 15, 0, 16'h0000, 4'b0000, 4'b0000, 4'h0, 8'h00, 0));
        t1.push_back(r(440, 15, 1, 16'h1111, 4'b0000, 4'b0000, 4'h2, 8'h5B, 0));
        t1.push_back(r(450, 15, 1, 16'h2222, 4'b0000, 4'b0000, 4'h0, 8'h00, 0));
        t1.push_back(r(460, 15, 0, 16'h0000, 4'b0000, 4'b0000, 4'h4, 8'hF7, 0));
        t1.push_back(r(511, 15, 0, 16'h0000, 4'b0000, 4'b0000, 4'h8, 8'h06, 0));
        t1.push_back(r(512, 15, 0, 16'h0000, 4'b0000, 4'b0000, 4'h8, 8'h06, 1));
        t1.push_back(r(515, 15, 0, 16'h0000, 4'b0000, 4'b0000, 4'h1, 8'h5B, 0));
        t1.push_back(r(547, 15, 0, 16'h0000, 4'b0000, 4'b0000, 4'h2, 8'h5B, 0));
        t1.push_back(r(639, 15, 1, 16'h4567, 4'b0000, 4'b0000, 4'h8, 8'h5B, 0));
        t1.push_back(r(640, 15, 0, 16'h0000, 4'b0000, 4'b0000, 4'h8, 8'h5B, 1));
        t1.push_back(r(643, 15, 0, 16'h0000, 4'b0000, 4'b0000, 4'h1, 8'h07, 0));
        t1.push_back(r(650, 15, 1, 16'h4567, 4'b0000, 4'b0010, 4'h1, 8'h07, 0));
        t1.push_back(r(675, 15, 0, 16'h0000, 4'b0000, 4'b0000, 4'h2, 8'h7D, 0));
        t1.push_back(r(768, 15, 0, 16'h0000, 4'b0000, 4'b0000, 4'h8, 8'h66, 1));
        t1.push_back(r(771, 15, 0, 16'h0000, 4'b0000, 4'b0000, 4'h1, 8'h07, 0));
        t1.push_back(r(803, 15, 0, 16'h0000, 4'b0000, 4'b0000, 4'h0, 8'h00, 0));
        t1.push_back(r(810, 15, 0, 16'h0000, 4'b0000, 4'b0000, 4'h0, 8'h00, 0));
        t1.push_back(r(835, 15, 0, 16'h0000, 4'b0000, 4'b0000, 4'h4, 8'h6D, 0));
        // After the mid-frame reset: display cleared, scan restarts at digit 0.
        t2.push_back(r(  1, 15, 0, 16'h0000, 4'b0000, 4'b0000, 4'h0, 8'h00, 0));
        t2.push_back(r(  3, 15, 0, 16'h0000, 4'b0000, 4'b0000, 4'h1, 8'h3F, 0));
        t2.push_back(r( 10, 15, 1, 16'h0030, 4'b0000, 4'b0000, 4'h1, 8'h3F, 0));
        t2.push_back(r( 35, 15, 0, 16'h0000, 4'b0000, 4'b0000, 4'h2, 8'h3F, 0));
        t2.push_back(r(128, 15, 0, 16'h0000, 4'b0000, 4'b0000, 4'h8, 8'h3F, 1));
        t2.push_back(r(131, 15, 0, 16'h0000, 4'b0000, 4'b0000, 4'h1, 8'h3F, 0));
        t2.push_back(r(163, 15, 0, 16'h0000, 4'b0000, 4'b0000, 4'h2, 8'h4F, 0));
`ifdef TUBE_SCANNER_LZS_EN
        t2.push_back(r(195, 15, 0, 16'h0000, 4'b0000, 4'b0000, 4'h0, 8'h00, 0));
        t2.push_back(r(227, 15, 0, 16'h0000, 4'b0000, 4'b0000, 4'h0, 8'h00, 0));
        t2.push_back(r(230, 15, 1, 16'h0000, 4'b0000, 4'b0000, 4'h0, 8'h00, 0));
        t2.push_back(r(259, 15, 0, 16'h0000, 4'b0000, 4'b0000, 4'h1, 8'h3F, 0));
        t2.push_back(r(291, 15, 0, 16'h0000, 4'b0000, 4'b0000, 4'h0, 8'h00, 0));
`else
        t2.push_back(r(195, 15, 0, 16'h0000, 4'b0000, 4'b0000, 4'h4, 8'h3F, 0));
        t2.push_back(r(227, 15, 0, 16'h0000, 4'b0000, 4'b0000, 4'h8, 8'h3F, 0));
        t2.push_back(r(230, 15, 1, 16'h0000, 4'b0000, 4'b0000, 4'h8, 8'h3F, 0));
        t2.push_back(r(259, 15, 0, 16'h0000, 4'b0000, 4'b0000, 4'h1, 8'h3F, 0));
        t2.push_back(r(291, 15, 0, 16'h0000, 4'b0000, 4'b0000, 4'h2, 8'h3F, 0));
`endif

        #12;
        chk("reset dig", 32'(tubeDig), 32'h0);
        chk("reset seg", 32'(tubeSeg), 32'h0);
        chk("reset fd", 32'(frame_done), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        foreach (t1[i]) do_row(t1[i], "t1");

        // Output was lit at this point; reset must darken it without a clock edge.
        #3;
        rst_n = 1'b0;
        #1;
        chk("async rst dig", 32'(tubeDig), 32'h0);
        chk("async rst seg", 32'(tubeSeg), 32'h0);
        #20;
        @(negedge clk);
        rst_n = 1'b1;
        foreach (t2[i]) do_row(t2[i], "t2");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
